// File: rtl/data_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
// Used by data_mem_arbiter and rr_arbiter2.
package data_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } arb_state_e;

  localparam int REQ_CPU = 0;
  localparam int REQ_AUX = 1;

  // One-hot grant vector for a requester index.
  function automatic logic [1:0] req_onehot(input logic idx);
    req_onehot = idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant selection for the data memory arbiter; owns last_grant.
// DATA_ARB_FIXED_PRIORITY_EN selects fixed priority (requester 0 always wins).
module rr_arbiter2
  import data_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_valid,
  input  logic       advance,
  output logic [1:0] grant
);

`ifdef DATA_ARB_FIXED_PRIORITY_EN
  // Requester 0 wins every contention; requester 1 may starve.
  always_comb begin
    grant = 2'b00;
    if (req_valid[REQ_CPU]) begin
      grant = req_onehot(1'b0);
    end else if (req_valid[REQ_AUX]) begin
      grant = req_onehot(1'b1);
    end else begin
      grant = 2'b00;
    end
  end
`else
  logic last_grant_r;

  // On contention the requester not granted last time wins.
  always_comb begin
    grant = 2'b00;
    if (req_valid == 2'b11) begin
      grant = req_onehot(~last_grant_r);
    end else begin
      grant = req_valid;
    end
  end

  // Remember who won the most recent accepted request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_r <= 1'b1;
    end else if (advance) begin
      last_grant_r <= grant[REQ_AUX];
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the synchronous-read data memory between the CPU and an auxiliary master.
// Arbitration policy is set in rr_arbiter2 (DATA_ARB_FIXED_PRIORITY_EN for fixed priority).
module data_mem_arbiter
  import data_arb_pkg::*;
#(
  parameter int WIDTH_DATA = 16,
  parameter int DAWIDTH    = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [DAWIDTH-1:0]    req0_addr,
  input  logic [WIDTH_DATA-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [WIDTH_DATA-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [DAWIDTH-1:0]    req1_addr,
  input  logic [WIDTH_DATA-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [WIDTH_DATA-1:0] rsp1_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DAWIDTH-1:0]    mem_addr,
  output logic [WIDTH_DATA-1:0] mem_wdata,
  input  logic [WIDTH_DATA-1:0] mem_rdata
);

  arb_state_e            state_r;
  logic                  owner_r;
  logic [1:0]            grant_s;
  logic [1:0]            ready_s;
  logic                  accept_s;
  logic                  sel_we_s;
  logic [DAWIDTH-1:0]    sel_addr_s;
  logic [WIDTH_DATA-1:0] sel_wdata_s;
  logic [1:0]            rsp_valid_r;
  logic [WIDTH_DATA-1:0] rsp_rdata_r [2];
  logic                  mem_en_r;
  logic                  mem_we_r;
  logic [DAWIDTH-1:0]    mem_addr_r;
  logic [WIDTH_DATA-1:0] mem_wdata_r;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid ({req1_valid, req0_valid}),
    .advance   (accept_s),
    .grant     (grant_s)
  );

  // Grants are honoured only in IDLE; ready also drops at once under reset.
  always_comb begin
    ready_s     = 2'b00;
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    if (reset_n && (state_r == IDLE)) begin
      ready_s = grant_s;
    end else begin
      ready_s = 2'b00;
    end
    if (grant_s[REQ_AUX]) begin
      sel_we_s    = req1_we;
      sel_addr_s  = req1_addr;
      sel_wdata_s = req1_wdata;
    end else begin
      sel_we_s    = req0_we;
      sel_addr_s  = req0_addr;
      sel_wdata_s = req0_wdata;
    end
  end

  assign accept_s = |ready_s;

  // Access sequencer: the memory bus registers double as the latched request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      owner_r        <= 1'b0;
      rsp_valid_r    <= 2'b00;
      rsp_rdata_r[0] <= '0;
      rsp_rdata_r[1] <= '0;
      mem_en_r       <= 1'b0;
      mem_we_r       <= 1'b0;
      mem_addr_r     <= '0;
      mem_wdata_r    <= '0;
    end else begin
      mem_en_r    <= 1'b0;
      rsp_valid_r <= 2'b00;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            owner_r     <= grant_s[REQ_AUX];
            mem_en_r    <= 1'b1;
            mem_we_r    <= sel_we_s;
            mem_addr_r  <= sel_addr_s;
            mem_wdata_r <= sel_wdata_s;
            state_r     <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (mem_we_r) begin
            rsp_valid_r[owner_r] <= 1'b1;
            state_r              <= IDLE;
          end else begin
            state_r <= CAPTURE;
          end
        end
        CAPTURE: begin
          rsp_rdata_r[owner_r] <= mem_rdata;
          rsp_valid_r[owner_r] <= 1'b1;
          state_r              <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready = ready_s[REQ_CPU];
  assign req1_ready = ready_s[REQ_AUX];
  assign rsp0_valid = rsp_valid_r[REQ_CPU];
  assign rsp1_valid = rsp_valid_r[REQ_AUX];
  assign rsp0_rdata = rsp_rdata_r[REQ_CPU];
  assign rsp1_rdata = rsp_rdata_r[REQ_AUX];
  assign mem_en     = mem_en_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter that shares the single-port, synchronous-read data memory (10-bit word address, 16-bit data) between the stack CPU's data port and a second master (program/data loader or debug port). Each requester uses a valid/ready request channel and a one-cycle response pulse. The arbiter issues one memory access at a time, sequences the memory's one-cycle read latency, and returns read data only to the requester that issued the access.

## Interface
- `WIDTH_DATA`, 16, data word width
- `DAWIDTH`, 10, data memory address width
- `clk`  in  1  clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req0_valid`  in  1  CPU request pending
- `req0_we`  in  1  1 = write, 0 = read
- `req0_addr`  in  DAWIDTH  word address
- `req0_wdata`  in  WIDTH_DATA  write data
- `req0_ready`  out  1  request accepted this cycle
- `rsp0_valid`  out  1  one-cycle response pulse
- `rsp0_rdata`  out  WIDTH_DATA  read data, valid with rsp0_valid on reads
- `req1_*` / `rsp1_*`: same set and meaning for requester 1
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  DAWIDTH  memory address
- `mem_wdata`  out  WIDTH_DATA  memory write data
- `mem_rdata`  in  WIDTH_DATA  memory read data, valid the cycle after a read strobe

## Operation
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE: if any reqN_valid, grant one requester. reqN_ready = 1 combinationally for the granted requester only. Latch we/addr/wdata/owner -> ISSUE. No request -> stay in IDLE.
- ISSUE: mem_en = 1, mem_we/addr/wdata from the latched request (registered outputs). Write -> IDLE and pulse rspN_valid the next cycle. Read -> CAPTURE.
- CAPTURE: sample mem_rdata into rspN_rdata of the owner, pulse rspN_valid the next cycle, -> IDLE.
- Default arbitration is round-robin. last_grant register; the requester not granted last wins on contention. Reset value of last_grant is 1, so requester 0 wins the first contention.
- A single requester gets back-to-back grants with no penalty.
- The request must stay stable while valid and not ready; the arbiter never accepts a changed request mid-hold.
- The non-owner's rsp_valid stays 0. Its rsp_rdata holds its previous value.
- Writes leave rspN_rdata unchanged.
- Reset (any time, including mid-ISSUE/CAPTURE): state = IDLE, last_grant = 1, all outputs 0 (ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata). An in-flight transaction is dropped with no response.

## Timing
- Accept edge T (valid & ready). ISSUE in cycle T+1, with mem_en high that cycle only.
- Write: rsp_valid high in cycle T+2.
- Read: mem_rdata is valid in T+2 (CAPTURE). rsp_valid and rsp_rdata are high/valid in T+3.
- Throughput: one write per 2 cycles; one read per 3 cycles.
- The arbiter is back in IDLE in the cycle rsp_valid is high, so a new accept can happen in that same cycle.
- mem_en is never asserted in two consecutive cycles.

## Configuration
- `DATA_ARB_FIXED_PRIORITY_EN` defined: requester 0 always wins contention. last_grant is not implemented. Requester 1 can starve.
- Undefined (default): round-robin as above.

## Structure
- Package `data_arb_pkg`:
  - state enum (IDLE, ISSUE, CAPTURE)
  - requester index constants REQ_CPU = 0, REQ_AUX = 1
- Sub-module `rr_arbiter2`:
  - combinational grant from two valids plus the last_grant register
  - owns last_grant
  - contains the `DATA_ARB_FIXED_PRIORITY_EN` switch

## Test plan
- Requester 0 writes 0xBEEF to 0x005, then reads 0x005:
  - mem_en pulses in T+1
  - write ack in T+2
  - read returns 0xBEEF with rsp0_valid exactly 3 cycles after accept
- Both valid every cycle, alternating addresses:
  - grants alternate 0,1,0,1 with the first grant to 0
  - each response goes to its own requester only
- Same stimulus with `DATA_ARB_FIXED_PRIORITY_EN` defined:
  - only requester 0 is granted
  - req1_ready stays 0
- Requester 1 reads 0x3FF (top address) while requester 0 is idle:
  - rsp1_rdata equals memory content
  - rsp0_valid stays 0
  - rsp0_rdata stays unchanged
- Assert reset_n = 0 during CAPTURE of a read:
  - outputs go to 0 asynchronously
  - no rsp_valid afterwards
  - the first post-reset contention grants requester 0
- Hold req0_valid with ready low while requester 1 owns the memory:
  - req0 is accepted on the first IDLE cycle
  - the accepted address/data equal the held values
